// File: rtl/bus_pkg.sv
// Shared types and helpers for the peripheral-bus interconnect.
//   state_e     : interconnect FSM encoding
//   SEL_FIELD_W : widest supported address select field
//   clog2 / sel_width : index-width helpers for the latched selection
package bus_pkg;

    localparam int unsigned SEL_FIELD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // Ceiling log2 for elaboration-time width calculations.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        longint unsigned v;
        r = 0;
        v = 1;
        while (v < longint'(n)) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    // Selection index width, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_interconnect_mux_if.sv
// Bus bundle between the load/store unit, the interconnect and its slaves.
//   req/addr/we       : master request, held until ready or err
//   rdata/ready/err   : response to the master
//   req_s/we_s        : per-slave request and write enable
//   rdata_s/ready_s   : per-slave read data (slave i at [i*WIDTH +: WIDTH]) and completion
// Modport slave is the interconnect's view; modport master is the environment
// (core plus slaves) driving it.
interface bus_interconnect_mux_if
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_SLAVES = 4
);
    logic                      req;
    logic [WIDTH-1:0]          addr;
    logic                      we;
    logic [WIDTH-1:0]          rdata;
    logic                      ready;
    logic                      err;
    logic [N_SLAVES-1:0]       req_s;
    logic [N_SLAVES-1:0]       we_s;
    logic [N_SLAVES*WIDTH-1:0] rdata_s;
    logic [N_SLAVES-1:0]       ready_s;

    modport slave (
        input  req, addr, we, rdata_s, ready_s,
        output rdata, ready, err, req_s, we_s
    );

    modport master (
        output req, addr, we, rdata_s, ready_s,
        input  rdata, ready, err, req_s, we_s
    );

endinterface

// File: rtl/bus_rdata_mux.sv
// N_SLAVES-way read-data mux from the flattened slave bus.
//   rdata_s : flattened slave read data, slave i at [i*WIDTH +: WIDTH]
//   sel     : latched slave index
//   en      : pass data only while a transfer is in flight, else 0
//   rdata_c : selected read data (combinational)
module bus_rdata_mux
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_SLAVES = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic [N_SLAVES*WIDTH-1:0] rdata_s,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      en,
    output logic [WIDTH-1:0]          rdata_c
);

    always_comb begin
        rdata_c = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (en && (sel == SEL_W'(i))) begin
                rdata_c = rdata_s[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/bus_interconnect_mux.sv
// Single-master to N-slave peripheral bus interconnect.
// Decodes addr[SEL_HI:SEL_LO] to a slave, forwards a req/ready handshake
// (slaves may insert wait states), muxes read data back and pulses err on a
// decode miss. Define BUS_TIMEOUT_EN to also abort a transfer whose slave
// stays silent for TIMEOUT cycles.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : bus_interconnect_mux_if.slave (master side and slave side signals)
module bus_interconnect_mux
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_SLAVES = 4,
    parameter int unsigned SEL_HI   = 31,
    parameter int unsigned SEL_LO   = 28,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bus_interconnect_mux_if.slave  bus
);

    localparam int unsigned SEL_W = sel_width(N_SLAVES);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               we_q, we_d;

    logic [SEL_FIELD_W-1:0] field_c;
    logic                   hit_c;
    logic                   busy_c;
    logic                   ready_sel_c;
    logic [N_SLAVES-1:0]    req_s_c;
    logic [N_SLAVES-1:0]    we_s_c;
    logic                   ready_c;
    logic                   err_c;
    logic [WIDTH-1:0]       rdata_c;
    logic                   unused_addr_c;

`ifdef BUS_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
`else
    localparam int unsigned unused_timeout_p = TIMEOUT;
`endif

    // Address decode: the select field is the slave index.
    assign field_c       = SEL_FIELD_W'(bus.addr[SEL_HI:SEL_LO]);
    assign hit_c         = (32'(field_c) < N_SLAVES);
    assign busy_c        = (state_q == ST_BUSY);
    assign unused_addr_c = ^bus.addr;

    // Completion strobe of the selected slave only; others are ignored.
    always_comb begin
        ready_sel_c = 1'b0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                ready_sel_c = bus.ready_s[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        req_s_c = '0;
        we_s_c  = '0;
        ready_c = 1'b0;
        err_c   = 1'b0;
`ifdef BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    if (hit_c) begin
                        sel_d   = SEL_W'(field_c);
                        we_d    = bus.we;
                        state_d = ST_BUSY;
`ifdef BUS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_BUSY: begin
                for (int unsigned i = 0; i < N_SLAVES; i++) begin
                    if (sel_q == SEL_W'(i)) begin
                        req_s_c[i] = 1'b1;
                        we_s_c[i]  = we_q;
                    end
                end
                ready_c = ready_sel_c;
                // A ready coinciding with the last allowed cycle still completes.
                if (ready_sel_c) begin
                    state_d = ST_IDLE;
                end
`ifdef BUS_TIMEOUT_EN
                else if ((32'(cnt_q) + 32'd1) >= TIMEOUT) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            ST_ERR: begin
                err_c   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    bus_rdata_mux #(
        .WIDTH    (WIDTH),
        .N_SLAVES (N_SLAVES),
        .SEL_W    (SEL_W)
    ) u_rdata_mux (
        .rdata_s (bus.rdata_s),
        .sel     (sel_q),
        .en      (busy_c),
        .rdata_c (rdata_c)
    );

    assign bus.req_s = req_s_c;
    assign bus.we_s  = we_s_c;
    assign bus.ready = ready_c;
    assign bus.err   = err_c;
    assign bus.rdata = rdata_c;

endmodule

// File: tb/tb_bus_interconnect_mux.sv
// Directed bench for bus_interconnect_mux (WIDTH=32, N_SLAVES=4, field [31:28]).
// Each record is one clock: inputs driven on the falling edge, outputs
// compared 1 ns later, state advances on the following rising edge.
module tb_bus_interconnect_mux;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned N_SLAVES = 4;
    localparam int unsigned TIMEOUT  = 15;
    localparam int          NV       = 24;

    localparam logic [31:0] D0 = 32'hDEAD_BEEF;
    localparam logic [31:0] D1 = 32'h1111_1111;
    localparam logic [31:0] D2 = 32'h2222_2222;
    localparam logic [31:0] D3 = 32'h3333_3333;

    typedef struct {
        logic        rst_n;
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  ready_s;
        logic [3:0]  e_req_s;
        logic [3:0]  e_we_s;
        logic        e_ready;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    vec_t vecs [NV];

    bus_interconnect_mux_if #(.WIDTH(WIDTH), .N_SLAVES(N_SLAVES)) bus ();

    bus_interconnect_mux #(
        .WIDTH    (WIDTH),
        .N_SLAVES (N_SLAVES),
        .SEL_HI   (31),
        .SEL_LO   (28),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic q, input logic [31:0] a,
                                input logic w, input logic [3:0] rs,
                                input logic [3:0] ers, input logic [3:0] ews,
                                input logic erdy, input logic eerr,
                                input logic [31:0] erd);
        vec_t v;
        v.rst_n   = r;
        v.req     = q;
        v.addr    = a;
        v.we      = w;
        v.ready_s = rs;
        v.e_req_s = ers;
        v.e_we_s  = ews;
        v.e_ready = erdy;
        v.e_err   = eerr;
        v.e_rdata = erd;
        return v;
    endfunction

    // Drive one cycle of inputs and compare the response.
    task automatic step(input string tag, input int idx, input vec_t v);
        logic [41:0] act;
        logic [41:0] exp;
        @(negedge clk);
        rst_n       = v.rst_n;
        bus.req     = v.req;
        bus.addr    = v.addr;
        bus.we      = v.we;
        bus.ready_s = v.ready_s;
        #1;
        act = {bus.req_s, bus.we_s, bus.ready, bus.err, bus.rdata};
        exp = {v.e_req_s, v.e_we_s, v.e_ready, v.e_err, v.e_rdata};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: req_s/we_s/ready/err/rdata got %b/%b/%b/%b/%h expected %b/%b/%b/%b/%h",
                     tag, idx, bus.req_s, bus.we_s, bus.ready, bus.err, bus.rdata,
                     v.e_req_s, v.e_we_s, v.e_ready, v.e_err, v.e_rdata);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        // rst, req, addr, we, ready_s | req_s, we_s, ready, err, rdata
        // Reset state
        vecs[0]  = mk(1, 0, 32'h0000_0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0);
        // Read slave 0, zero wait
        vecs[1]  = mk(1, 1, 32'h0000_0010, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 32'h0);
        vecs[2]  = mk(1, 1, 32'h0000_0010, 0, 4'b0001, 4'b0001, 4'b0000, 1, 0, D0);
        vecs[3]  = mk(1, 0, 32'h0000_0010, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 32'h0);
        // Write slave 2, three wait states; addr/we wobble mid-transfer
        vecs[4]  = mk(1, 1, 32'h2000_0004, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0);
        vecs[5]  = mk(1, 1, 32'h2000_0004, 1, 4'b0000, 4'b0100, 4'b0100, 0, 0, D2);
        vecs[6]  = mk(1, 1, 32'h0000_0000, 0, 4'b0000, 4'b0100, 4'b0100, 0, 0, D2);
        vecs[7]  = mk(1, 1, 32'h2000_0004, 1, 4'b0000, 4'b0100, 4'b0100, 0, 0, D2);
        vecs[8]  = mk(1, 1, 32'h2000_0004, 1, 4'b0100, 4'b0100, 4'b0100, 1, 0, D2);
        vecs[9]  = mk(1, 0, 32'h0000_0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0);
        // Decode miss
        vecs[10] = mk(1, 1, 32'h7000_0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0);
        vecs[11] = mk(1, 1, 32'h7000_0000, 0, 4'b1111, 4'b0000, 4'b0000, 0, 1, 32'h0);
        vecs[12] = mk(1, 0, 32'h0000_0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0);
        // Read slave 1 with foreign ready_s, then back-to-back to slave 3
        vecs[13] = mk(1, 1, 32'h1000_0000, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 32'h0);
        vecs[14] = mk(1, 1, 32'h1000_0000, 0, 4'b1101, 4'b0010, 4'b0000, 0, 0, D1);
        vecs[15] = mk(1, 1, 32'h1000_0000, 0, 4'b0010, 4'b0010, 4'b0000, 1, 0, D1);
        vecs[16] = mk(1, 1, 32'h3000_0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0);
        vecs[17] = mk(1, 1, 32'h3000_0000, 1, 4'b1000, 4'b1000, 4'b1000, 1, 0, D3);
        vecs[18] = mk(1, 0, 32'h0000_0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0);
        // Reset in the second BUSY cycle of a slave-1 transfer, late ready ignored
        vecs[19] = mk(1, 1, 32'h1000_0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0);
        vecs[20] = mk(1, 1, 32'h1000_0000, 0, 4'b0000, 4'b0010, 4'b0000, 0, 0, D1);
        vecs[21] = mk(0, 1, 32'h1000_0000, 0, 4'b0000, 4'b0010, 4'b0000, 0, 0, D1);
        vecs[22] = mk(1, 0, 32'h1000_0000, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0, 32'h0);
        vecs[23] = mk(1, 0, 32'h0000_0000, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0, 32'h0);

        rst_n       = 1'b0;
        bus.req     = 1'b0;
        bus.addr    = '0;
        bus.we      = 1'b0;
        bus.ready_s = '0;
        bus.rdata_s = {D3, D2, D1, D0};
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            step("vec", i, vecs[i]);
        end

`ifdef BUS_TIMEOUT_EN
        // Slave 3 never answers: 15 BUSY cycles, then one err pulse.
        step("to_idle", 0, mk(1, 1, 32'h3000_0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0));
        for (int c = 1; c <= int'(TIMEOUT); c++) begin
            step("to_busy", c, mk(1, 1, 32'h3000_0000, 0, 4'b0000, 4'b1000, 4'b0000, 0, 0, D3));
        end
        step("to_err", 0, mk(1, 1, 32'h3000_0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 32'h0));
        step("to_back", 0, mk(1, 0, 32'h0000_0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0));
        // Ready on the last allowed BUSY cycle wins over the timeout.
        step("tr_idle", 0, mk(1, 1, 32'h3000_0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0));
        for (int c = 1; c < int'(TIMEOUT); c++) begin
            step("tr_busy", c, mk(1, 1, 32'h3000_0000, 0, 4'b0000, 4'b1000, 4'b0000, 0, 0, D3));
        end
        step("tr_ready", 0, mk(1, 1, 32'h3000_0000, 0, 4'b1000, 4'b1000, 4'b0000, 1, 0, D3));
        step("tr_noerr", 0, mk(1, 0, 32'h0000_0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0));
`else
        // Without the timeout a silent slave keeps the bus busy indefinitely.
        step("wait_idle", 0, mk(1, 1, 32'h3000_0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0));
        for (int c = 1; c <= 40; c++) begin
            step("wait_busy", c, mk(1, 1, 32'h3000_0000, 0, 4'b0000, 4'b1000, 4'b0000, 0, 0, D3));
        end
        step("wait_ready", 0, mk(1, 1, 32'h3000_0000, 0, 4'b1000, 4'b1000, 4'b0000, 1, 0, D3));
        step("wait_done", 0, mk(1, 0, 32'h0000_0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
